// File: rtl/mdr_pkg.sv
// Shared types and defaults for the sequential multiply / divide / square-root unit.
package mdr_pkg;

    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_SQRT = 2'b10,
        OP_INV  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_Y,
        CALC,
        DONE
    } state_e;

endpackage

// File: rtl/mdr_addsub.sv
// Width-parametrised adder/subtractor; subtract is a + ~b + 1, cout=1 means no borrow.
module mdr_addsub #(
    parameter int W = 18
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] b_eff;
    logic [W:0]   full;

    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
    assign sum   = full[W-1:0];
    assign cout  = full[W];

endmodule

// File: rtl/mdr_seq_core.sv
// Sequential unsigned mul / div / sqrt sharing one add/sub; operands fetched via load_x/load_y handshake.
module mdr_seq_core
    import mdr_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          load,
    input  logic [1:0]    op,
    input  logic [DW-1:0] data,
    output logic          load_x,
    output logic          load_y,
    output logic          ready,
    output logic          error,
    output logic [DW-1:0] result,
    output logic [DW-1:0] remainder
);

    localparam int CW = $clog2(DW) + 1;
    localparam int HW = DW / 2;
    localparam int SW = HW + 2;
    localparam int AW = DW + 2;

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic          load_q, load_d;
    logic [DW-1:0] ra_q, ra_d;
    logic [DW-1:0] rb_q, rb_d;
    logic [DW-1:0] y_q, y_d;
    logic [HW-1:0] rc_q, rc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] rem_q, rem_d;

    logic [AW-1:0] add_a, add_b, add_sum;
    logic          add_sub, add_cout;
    logic          unused_sum_msb;

    logic [DW:0]   div_sh;
    logic [SW-1:0] sq_sh;
    logic [DW:0]   mul_new;
    logic [DW-1:0] it_ra, it_rb;
    logic [HW-1:0] it_rc;
    logic          load_rise;

    // ra: mul high half / div partial remainder / sqrt remainder
    // rb: mul multiplier+low half / div dividend+quotient / sqrt radicand
    // rc: sqrt partial root
    mdr_addsub #(.W(AW)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign unused_sum_msb = add_sum[AW-1];
    assign load_rise      = load & ~load_q;

    always_comb begin
        div_sh  = {ra_q, rb_q[DW-1]};
        sq_sh   = {ra_q[SW-3:0], rb_q[DW-1:DW-2]};
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (op_q)
            OP_MUL: begin
                add_a[DW-1:0] = ra_q;
                add_b[DW-1:0] = y_q;
            end
            OP_DIV: begin
                add_a[DW:0]   = div_sh;
                add_b[DW-1:0] = y_q;
                add_sub       = 1'b1;
            end
            default: begin
                add_a[SW-1:0] = sq_sh;
                add_b[SW-1:0] = {rc_q, 2'b01};
                add_sub       = 1'b1;
            end
        endcase
    end

    always_comb begin
        mul_new = {1'b0, ra_q};
        it_ra   = ra_q;
        it_rb   = rb_q;
        it_rc   = rc_q;
        case (op_q)
            OP_MUL: begin
                if (rb_q[0]) mul_new = add_sum[DW:0];
                it_ra = mul_new[DW:1];
                it_rb = {mul_new[0], rb_q[DW-1:1]};
            end
            OP_DIV: begin
                // restore on borrow: a remainder below Y always fits DW bits
                it_ra = add_cout ? add_sum[DW-1:0] : div_sh[DW-1:0];
                it_rb = {rb_q[DW-2:0], add_cout};
            end
            default: begin
                it_ra = '0;
                if (add_cout) it_ra = add_sum[DW-1:0];
                else          it_ra[SW-1:0] = sq_sh;
                it_rb = {rb_q[DW-3:0], 2'b00};
                it_rc = {rc_q[HW-2:0], add_cout};
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        load_d   = load;
        ra_d     = ra_q;
        rb_d     = rb_q;
        y_d      = y_q;
        rc_d     = rc_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        error_d  = error_q;
        result_d = result_q;
        rem_d    = rem_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    op_d     = op_e'(op);
                    ready_d  = 1'b0;
                    error_d  = 1'b0;
                    result_d = '0;
                    rem_d    = '0;
                    if (op_e'(op) == OP_INV) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = LOAD_X;
                    end
                end
            end
            LOAD_X: begin
                if (load_rise) begin
                    rb_d = data;
                    ra_d = '0;
                    rc_d = '0;
                    if (op_q == OP_SQRT) begin
                        state_d = CALC;
                        cnt_d   = CW'(HW);
                    end else begin
                        state_d = LOAD_Y;
                    end
                end
            end
            LOAD_Y: begin
                if (load_rise) begin
                    y_d = data;
                    if (op_q == OP_DIV && data == '0) begin
                        state_d  = DONE;
                        ready_d  = 1'b1;
                        error_d  = 1'b1;
                        result_d = '1;
                        rem_d    = rb_q;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(DW);
                    end
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                    ra_d  = it_ra;
                    rb_d  = it_rb;
                    rc_d  = it_rc;
                end else begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    rem_d   = ra_q;
                    if (op_q == OP_SQRT) begin
                        result_d         = '0;
                        result_d[HW-1:0] = rc_q;
                    end else begin
                        result_d = rb_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            load_q   <= 1'b0;
            ra_q     <= '0;
            rb_q     <= '0;
            y_q      <= '0;
            rc_q     <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            load_q   <= load_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            y_q      <= y_d;
            rc_q     <= rc_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
            result_q <= result_d;
            rem_q    <= rem_d;
        end
    end

    assign load_x    = (state_q == LOAD_X);
    assign load_y    = (state_q == LOAD_Y);
    assign ready     = ready_q;
    assign error     = error_q;
    assign result    = result_q;
    assign remainder = rem_q;

endmodule

// File: doc/mdr_seq_core.md
Name: mdr_seq_core

Overview:
Parametrised sequential multiply / divide / square-root unit for unsigned operands of width DW.
- Single shared add/sub datapath: shift-add multiply, restoring divide, restoring bit-pair square root.
- Load_X/Load_Y handshake prompts the host for operands.
- Successor to the fixed 16-bit MDR: generic width, full double-width product, divide-by-zero and invalid-op error reporting, start-ignored-while-busy protection.

Parameters:
DW, 16, operand/result width; must be even and >= 4.
CW, $clog2(DW)+1, iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  begin operation; sampled in IDLE and DONE only
load  in  1  operand strobe (level); internally edge-detected
op  in  2  00 mul, 01 div, 10 sqrt, 11 invalid; latched with start
data  in  DW  operand bus, captured on load rising edge
load_x  out  1  high while waiting for X
load_y  out  1  high while waiting for Y
ready  out  1  result valid, held until next accepted start
error  out  1  div-by-zero or invalid op; valid while ready=1
result  out  DW  mul: product[DW-1:0]; div: quotient; sqrt: root (upper DW/2 bits zero)
remainder  out  DW  mul: product[2DW-1:DW]; div: remainder; sqrt: X - root^2

Behaviour:
- Reset (rst=0, async, any state including mid-CALC):
  - state=IDLE; all outputs and internal registers 0.
  - Edge-detect register load_q=0, so a load held high across reset release counts as a rising edge.
- States: IDLE, LOAD_X, LOAD_Y, CALC, DONE.
- IDLE/DONE, start=1 at edge:
  - op latched; ready, error, result, remainder cleared.
  - op=11 -> DONE next cycle with error=1, result=0, remainder=0.
  - Otherwise -> LOAD_X.
- LOAD_X: load_x=1. On load rising edge (load=1 and load_q=0):
  - X <= data.
  - sqrt -> CALC; mul/div -> LOAD_Y.
- LOAD_Y: load_y=1. On load rising edge:
  - Y <= data.
  - div with data=0 -> DONE, error=1, result={DW{1'b1}}, remainder=X.
  - Otherwise -> CALC.
- Load held high: exactly one capture. A new edge is required for Y.
- start outside IDLE/DONE: ignored.
- CALC: counter loaded with the iteration count on entry; one iteration per cycle. Iteration counts: mul DW, div DW, sqrt DW/2. Leaving CALC -> DONE, ready=1 in the first DONE cycle.
- Latency from the Y-capture edge (X-capture edge for sqrt) to ready=1: mul DW+1, div DW+1, sqrt DW/2+1 cycles.
- mul: unsigned shift-add; accumulator 2DW bits; adder DW+1 bits wide, carry kept.
- div: restoring; partial remainder DW+1 bits; trial subtract Y each cycle; quotient bit = ~borrow; restore on borrow.
- sqrt: restoring, two radicand bits per iteration; trial subtract (root<<2)|1 on DW/2+2-bit remainder.
- Single add/sub instance shared by all three ops; subtract = A + ~B + 1.
- DONE: outputs stable until next accepted start or reset. load edges in DONE are ignored.
- Simultaneous start and load in IDLE: start wins. load_q updates every cycle regardless of state, so this load edge is consumed and not captured.

Decomposition:
- mdr_pkg holds:
  - DW default
  - op_e enum (OP_MUL=2'b00, OP_DIV=2'b01, OP_SQRT=2'b10, OP_INV=2'b11)
  - state_e enum (IDLE, LOAD_X, LOAD_Y, CALC, DONE)
- One sub-module: mdr_addsub.
  - Parametrised width W.
  - Ports a, b, sub, sum[W-1:0], cout.
  - Instantiated once at W=DW+2.
- FSM, edge detect, counter and shift registers live in mdr_seq_core.

Test Plan:
1. DW=16, mul X=300, Y=200 -> ready after 17 cycles; result=16'hEA60, remainder=0, error=0. Then X=Y=16'hFFFF -> result=16'h0001, remainder=16'hFFFE.
2. div X=100, Y=7 -> ready after 17 cycles; result=14, remainder=2. Then div X=5, Y=0 -> DONE one cycle after Y capture; error=1, result=16'hFFFF, remainder=5.
3. sqrt X=1000 -> load_y never asserts; ready after 9 cycles; result=31, remainder=39. Then X=16'hFFFF -> result=255, remainder=510.
4. op=11 with start -> next cycle ready=1, error=1, result=0, load_x never asserts.
5. Load held high 10 cycles in LOAD_X -> single X capture; FSM stays in LOAD_Y until load drops and rises again. start pulsed during CALC -> no effect on result.
6. Assert rst=0 mid-CALC of a multiply -> all outputs 0 immediately, state IDLE. After release, a new div 100/7 completes correctly. Repeat at DW=8: mul 15*17 -> result=8'hFF, remainder=0.
